mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 mux output path among four requesters.
- Owns the mux select lines. Grants one requester at a time for a bounded burst and presents the selected data downstream with a valid/ready handshake.
- Sits directly in front of the shared 4:1 datapath mux. It is the only agent that drives its select inputs.

---
 rtl/mux4_rr_arbiter_pkg.sv | 10 +
 rtl/mux4_rr_arbiter_mux4_w.sv | 13 +
 rtl/mux4_rr_arbiter.sv | 69 ++++++
 tb/tb_mux4_rr_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// mux4_rr_arbiter_pkg: shared constants for the round-robin 4:1 mux arbiter
package mux4_rr_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
  localparam int NUM_REQ = 4;
  localparam int DEF_MAX_HOLD = 4;
  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;
endpackage

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// mux4_w: WIDTH-bit 4:1 mux driven by a 2-bit select
module mux4_w #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);
  assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared 4:1 mux with bounded bursts and valid/ready output
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_d,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] dout,
  output logic [3:0]       ack
);
  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx, owner, sel_nx;
  logic [3:0] cnt, cnt_nx;
  logic       found, acc, rel, arb;
  always_comb begin
    owner = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        found = 1'b1;
        owner = ptr + 2'(i);
      end
    end
  end
  assign gnt       = (state == GRANT) ? (4'b0001 << sel) : 4'b0000;
  assign out_valid = rst_n && (state == GRANT) && req[sel];
  assign acc       = out_valid && out_ready;
  assign ack       = gnt & {4{acc}};
  assign rel       = (state == GRANT) && (!req[sel] || (acc && cnt == 4'(MAX_HOLD - 1)));
  assign arb       = (state == IDLE) || rel;
  always_comb begin
    state_nx = arb ? (found ? GRANT : IDLE) : state;
    sel_nx   = (arb && found) ? owner : sel;
    ptr_nx   = (arb && found) ? owner + 2'd1 : ptr;
    cnt_nx   = arb ? 4'd0 : cnt + 4'(acc);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= REQ_A;
      ptr   <= REQ_A;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
    end
  end
  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .sel(sel),
    .d0 (din_a),
    .d1 (din_b),
    .d2 (din_c),
    .d3 (din_d),
    .y  (dout)
  );
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed self-checking bench for the round-robin mux arbiter
module tb_mux4_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] din_a, din_b, din_c, din_d;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;
  logic [7:0] dout;
  logic [3:0] ack;
  int total = 0;
  int bad = 0;
  logic [7:0] dat [4];
  int acks;
  always #5 clk = ~clk;
  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .din_a(din_a),
    .din_b(din_b),
    .din_c(din_c),
    .din_d(din_d),
    .out_ready(out_ready),
    .sel(sel),
    .gnt(gnt),
    .out_valid(out_valid),
    .dout(dout),
    .ack(ack)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_owner(input string tag, input int o, input logic rdy);
    chk({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << o));
    chk({tag, "_sel"}, 32'(sel), 32'(o));
    chk({tag, "_dout"}, 32'(dout), 32'(dat[o]));
    chk({tag, "_ack"}, 32'(ack), rdy ? 32'(4'b0001 << o) : 32'd0);
  endtask
  initial begin
    dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2; dat[3] = 8'hD3;
    din_a = dat[0]; din_b = dat[1]; din_c = dat[2]; din_d = dat[3];
    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    for (int g = 0; g < 6; g++) begin
      acks = 0;
      for (int b = 0; b < 4; b++) begin
        chk_owner("rr", g % 4, 1'b1);
        if (ack != 4'b0000) acks++;
        tick();
      end
      chk("rr_ackcount", 32'(acks), 32'd4);
    end
    chk_owner("bp_start", 2, 1'b1);
    tick();
    chk_owner("bp_beat2", 2, 1'b1);
    tick();
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      chk_owner("bp_stall", 2, 1'b0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk_owner("bp_resume3", 2, 1'b1);
    tick();
    chk_owner("bp_resume4", 2, 1'b1);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk_owner("d_burst", 3, 1'b1);
      tick();
    end
    chk_owner("a_regrant", 0, 1'b1);
    req = 4'b1010;
    #1;
    chk("a_drop_valid", 32'(out_valid), 32'd0);
    chk("a_drop_ack", 32'(ack), 32'd0);
    tick();
    chk_owner("er_b1", 1, 1'b1);
    tick();
    chk_owner("er_b2", 1, 1'b1);
    tick();
    req = 4'b1000;
    #1;
    chk("er_drop_valid", 32'(out_valid), 32'd0);
    tick();
    chk_owner("er_to_d", 3, 1'b1);
    req = 4'b0100;
    #1;
    tick();
    for (int c = 0; c < 12; c++) begin
      chk_owner("single", 2, 1'b1);
      tick();
    end
    req = 4'b1000;
    #1;
    tick();
    chk_owner("mr_b1", 3, 1'b1);
    tick();
    chk_owner("mr_b2", 3, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_rst_valid", 32'(out_valid), 32'd0);
    chk("mr_rst_ack", 32'(ack), 32'd0);
    tick();
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_sel", 32'(sel), 32'd0);
    rst_n = 1'b1;
    req = 4'b1010;
    #1;
    tick();
    chk_owner("mr_ptr0", 1, 1'b1);
    req = 4'b0000;
    #1;
    tick();
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_sel_hold", 32'(sel), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    req = 4'b0001;
    #1;
    chk("idle_latency_gnt", 32'(gnt), 32'd0);
    tick();
    chk_owner("idle_regrant", 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
